// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: read FSM states and the
// {video, cpu} routing tag carried alongside every issued RAM operation.
package vram_pkg;

  localparam int unsigned VramAddrW = 17;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RIssue,
    RDone
  } rd_state_e;

  typedef logic [1:0] tag_t;

  localparam tag_t TagNone = 2'b00;
  localparam tag_t TagCpu  = 2'b01;
  localparam tag_t TagVid  = 2'b10;

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO: power-of-two depth, registered full/empty flags, no
// bypass, so a pushed entry is visible at the head one cycle later.
module vram_wfifo #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-latency video reads, posted CPU writes via a
// small FIFO, and CPU reads ordered behind any pending writes.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VramAddrW,
  parameter int unsigned WDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic [7:0]        v_data,
  output logic              v_valid,
  input  logic              c_wr,
  output logic              c_wready,
  input  logic              c_rd,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [7:0]        c_wdata,
  output logic [7:0]        c_rdata,
  output logic              c_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned CntW = $clog2(WDEPTH) + 1;

  logic              fifo_full, fifo_empty, push, pop, cpu_rd_issue;
  logic [ADDR_W+7:0] fifo_head;
  logic [CntW-1:0]   fifo_count;

  rd_state_e         rd_state_q;
  tag_t              tag_d, tag1_q, tag2_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [7:0]        mem_wdata_d, mem_wdata_q, v_data_q, c_rdata_q;
  logic              mem_we_d, mem_we_q, v_valid_q, c_rvalid_q;

  assign c_wready = (fifo_count < CntW'(WDEPTH));
  assign push     = c_wr && !fifo_full;

  vram_wfifo #(
    .Width (ADDR_W + 8),
    .Depth (WDEPTH)
  ) u_wfifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({c_addr, c_wdata}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Requiring an empty FIFO for the CPU read is what gives read-after-write order.
  assign cpu_rd_issue = (rd_state_q == RWait) && fifo_empty && !v_req;
  assign pop          = !v_req && !fifo_empty;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    tag_d       = TagNone;
    if (v_req) begin
      mem_addr_d = v_addr;
      tag_d      = TagVid;
    end else if (cpu_rd_issue) begin
      mem_addr_d = c_addr;
      tag_d      = TagCpu;
    end else if (pop) begin
      mem_addr_d  = fifo_head[ADDR_W+7:8];
      mem_wdata_d = fifo_head[7:0];
      mem_we_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tag1_q      <= TagNone;
      tag2_q      <= TagNone;
      v_valid_q   <= 1'b0;
      v_data_q    <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      // tag2_q lines up with mem_rdata for the operation that produced it.
      tag1_q      <= tag_d;
      tag2_q      <= tag1_q;
      v_valid_q   <= (tag2_q == TagVid);
      if (tag2_q == TagVid) v_data_q <= mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RIdle;
      c_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= 1'b0;
      unique case (rd_state_q)
        RIdle:  if (c_rd) rd_state_q <= RWait;
        RWait:  if (cpu_rd_issue) rd_state_q <= RIssue;
        RIssue: begin
          if (tag2_q == TagCpu) begin
            rd_state_q <= RDone;
            c_rvalid_q <= 1'b1;
            c_rdata_q  <= mem_rdata;
          end
        end
        RDone:  rd_state_q <= RIdle;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign v_data    = v_data_q;
  assign v_valid   = v_valid_q;
  assign c_rdata   = c_rdata_q;
  assign c_rvalid  = c_rvalid_q;

endmodule
